uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart_tx serializer among N_REQ byte requesters.
- Arbitrates pending requests, latches the winner's byte, and pulses the serializer's start line.
- Tracks frame completion through the serializer's idle_ready, then enforces a programmable inter-frame idle gap (stop time) before the next frame.
- Sits between the requesting client blocks and the uart_tx instance.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- STOP_CYCLES, 2, extra idle cycles inserted after each frame completes (0..255).
- PTR_W, $clog2(N_REQ), width of the requester index (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  per-requester request; held high until the matching gnt bit is seen.
- req_data  in  8*N_REQ  byte for requester i at bits [8*i+7:8*i]; stable while req[i] is high.
- gnt  out  N_REQ  one-hot, one-cycle acknowledge; byte consumed.
- uart_start  out  1  to uart_tx start.
- uart_data  out  8  to uart_tx data.
- uart_idle_ready  in  1  from uart_tx idle_ready.
- busy  out  1  high in any state other than IDLE.
- cur_src  out  PTR_W  index of the last granted requester.
- frame_count  out  16  frames issued since reset; wraps 0xFFFF -> 0x0000.

Behaviour:
- All outputs are registered.
- Reset (synchronous, wins over everything, also mid-frame):
  - state = INIT; gnt = 0; uart_start = 0; uart_data = 0x00; busy = 1; cur_src = N_REQ-1; frame_count = 0; gap counter = 0.
  - The serializer is reset by the same rst, so no frame is abandoned half-driven on tx.
- State machine, one transition evaluated per clk:
  - INIT: exactly one cycle after rst deasserts, giving the serializer its initialise cycle; then -> IDLE.
  - IDLE: busy = 0. If (|req) and uart_idle_ready:
    - Winner = first set req bit scanning cur_src+1, cur_src+2, ... modulo N_REQ.
    - Latch req_data of the winner into uart_data; cur_src <= winner.
    - Go to ISSUE.
    - If either condition is false, remain in IDLE.
  - ISSUE: exactly one cycle.
    - uart_start = 1, gnt[cur_src] = 1, uart_data holds the latched byte.
    - frame_count increments on exit; -> WAIT_DONE.
  - WAIT_DONE: uart_start = 0; uart_data is held. On uart_idle_ready = 1:
    - STOP_CYCLES == 0 -> IDLE.
    - Otherwise load the gap counter with STOP_CYCLES-1 and go to GAP.
  - GAP: decrement the counter; at 0 -> IDLE.
- Requests and data changes are ignored outside IDLE.
- A requester that drops req before its grant simply loses its turn; there is no error.
- Requests that rise in the same cycle are resolved only by the rotating priority.
- A requester that is still requesting after its grant (next byte) is served after every other pending requester.
- Line timing for uncontended back-to-back frames, counting the cycle req is first seen in IDLE as 0:
  - Cycle 1: ISSUE.
  - Cycle 2: start bit on tx.
  - Cycles 3..10: data bits, LSB first.
  - Cycle 11: idle_ready high.
  - Next ISSUE at cycle 13+STOP_CYCLES.
  - tx is high for STOP_CYCLES+3 cycles between frames.
- Idle_ready dropping unexpectedly in IDLE: stay in IDLE; never start without idle_ready.
- uart_start is never high for 2 consecutive cycles.
- gnt is never high outside ISSUE.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding localparams: INIT, IDLE, ISSUE, WAIT_DONE, GAP (3-bit).
  - Frame constant DATA_BITS = 8.
- One natural sub-module: rr_pick, a combinational rotating-priority selector.
  - Inputs: req vector and last index.
  - Outputs: winner index and valid.
  - Reusable by future arbiters in the codebase.

Test Plan:
- Single request, STOP_CYCLES=2: req[2]=1, data 0xA5 at cycle 0 -> gnt=0b0100 and uart_start at cycle 1 only; tx = 0,1,0,1,0,0,1,0,1 on cycles 2..10; frame_count=1; busy low from cycle 14.
- All four request simultaneously after reset, data 0x11, 0x22, 0x33, 0x44 -> grant order 0,1,2,3; four frames; ISSUE cycles spaced 14 apart; frame_count=4.
- Fairness: req[1] held continuously (8 bytes), req[3] raised after first grant -> grants alternate 1,3,1,3; no requester is granted twice while the other pends.
- STOP_CYCLES=0 -> ISSUE cycles spaced 12 apart; tx high exactly 3 cycles between frames.
- Reset mid-frame (rst high at cycle 6 of a frame) -> next cycle gnt=0, uart_start=0, tx=1; one INIT cycle; a pending request is re-issued from IDLE with full frame timing.
- frame_count preset by running 65536 frames (or force) -> wraps to 0x0000 without affecting arbitration.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbitration path.
package uart_pkg;

  // Arbiter state encoding (3-bit)
  localparam logic [2:0] INIT      = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] ISSUE     = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  // Payload bits per UART frame
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StInit     = INIT,
    StIdle     = IDLE,
    StIssue    = ISSUE,
    StWaitDone = WAIT_DONE,
    StGap      = GAP
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority selector: picks the first set request bit
// scanning upward from the index after last_i, wrapping modulo NReq.
module rr_pick #(
  parameter int unsigned NReq = 4,
  parameter int unsigned PtrW = $clog2(NReq)
) (
  input  logic [NReq-1:0] req_i,
  input  logic [PtrW-1:0] last_i,
  output logic [PtrW-1:0] idx_o,
  output logic            valid_o
);

  logic [PtrW-1:0] pos;

  // Scan farthest-first so the nearest set bit after last_i is the final write
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    pos     = '0;
    for (int i = NReq; i > 0; i--) begin
      pos = PtrW'((32'(last_i) + 32'(i)) % NReq);
      if (req_i[pos]) begin
        idx_o = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer among N_REQ byte
// requesters, with a programmable idle gap after every frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned N_REQ       = 4,
  parameter  int unsigned STOP_CYCLES = 2,
  localparam int unsigned PTR_W       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [8*N_REQ-1:0]     req_data_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic                   uart_start_o,
  output logic [DATA_BITS-1:0]   uart_data_o,
  input  logic                   uart_idle_ready_i,
  output logic                   busy_o,
  output logic [PTR_W-1:0]       cur_src_o,
  output logic [15:0]            frame_count_o
);

  arb_state_e           state_q, state_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic                 start_q, start_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 busy_q, busy_d;
  logic [PTR_W-1:0]     cur_q, cur_d;
  logic [15:0]          fcount_q, fcount_d;
  logic [7:0]           gap_q, gap_d;

  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_valid;

  rr_pick #(
    .NReq (N_REQ),
    .PtrW (PTR_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .last_i  (cur_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Next-state and registered-output decode; start/gnt are set on entry to
  // ISSUE so that they appear, registered, for exactly the ISSUE cycle.
  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    start_d  = 1'b0;
    data_d   = data_q;
    cur_d    = cur_q;
    fcount_d = fcount_q;
    gap_d    = gap_q;
    unique case (state_q)
      StInit: begin
        state_d = StIdle;
      end
      StIdle: begin
        // Never launch a frame unless the serializer reports idle
        if (pick_valid && uart_idle_ready_i) begin
          state_d = StIssue;
          data_d  = req_data_i[DATA_BITS*pick_idx +: DATA_BITS];
          cur_d   = pick_idx;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          start_d = 1'b1;
        end
      end
      StIssue: begin
        fcount_d = fcount_q + 16'd1;
        state_d  = StWaitDone;
      end
      StWaitDone: begin
        if (uart_idle_ready_i) begin
          if (STOP_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            gap_d   = 8'(STOP_CYCLES - 1);
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers; synchronous reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StInit;
      gnt_q    <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b1;
      cur_q    <= PTR_W'(N_REQ - 1);
      fcount_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      start_q  <= start_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      cur_q    <= cur_d;
      fcount_q <= fcount_d;
      gap_q    <= gap_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign uart_start_o  = start_q;
  assign uart_data_o   = data_q;
  assign busy_o        = busy_q;
  assign cur_src_o     = cur_q;
  assign frame_count_o = fcount_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (STOP_CYCLES=2 and 0),
// each paired with a small behavioural uart_tx serializer model.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: STOP_CYCLES = 2
  logic [3:0]  req_a = '0;
  logic [31:0] data_a = '0;
  logic [3:0]  gnt_a;
  logic        start_a, ir_a, busy_a, tx_a;
  logic [7:0]  udata_a;
  logic [1:0]  cur_a;
  logic [15:0] fc_a;

  // Instance B: STOP_CYCLES = 0
  logic [3:0]  req_b = '0;
  logic [31:0] data_b = '0;
  logic [3:0]  gnt_b;
  logic        start_b, ir_b, busy_b, tx_b;
  logic [7:0]  udata_b;
  logic [1:0]  cur_b;
  logic [15:0] fc_b;

  uart_tx_arbiter #(.N_REQ(4), .STOP_CYCLES(2)) dut_a (
    .clk (clk), .rst (rst), .req_i (req_a), .req_data_i (data_a), .gnt_o (gnt_a),
    .uart_start_o (start_a), .uart_data_o (udata_a), .uart_idle_ready_i (ir_a),
    .busy_o (busy_a), .cur_src_o (cur_a), .frame_count_o (fc_a)
  );

  uart_tx_arbiter #(.N_REQ(4), .STOP_CYCLES(0)) dut_b (
    .clk (clk), .rst (rst), .req_i (req_b), .req_data_i (data_b), .gnt_o (gnt_b),
    .uart_start_o (start_b), .uart_data_o (udata_b), .uart_idle_ready_i (ir_b),
    .busy_o (busy_b), .cur_src_o (cur_b), .frame_count_o (fc_b)
  );

  // Serializer model: cnt 0 idle (tx=1), 1 start bit, 2..9 data LSB first.
  // idle_ready is held low for one initialise cycle after reset.
  logic [3:0] scnt_a, scnt_b;
  logic [7:0] ssh_a, ssh_b;
  logic       sinit_a, sinit_b;

  function automatic logic tx_of(input logic [3:0] c, input logic [7:0] sh);
    logic [3:0] k;
    k = c - 4'd2;
    if (c == 4'd0) return 1'b1;
    if (c == 4'd1) return 1'b0;
    return sh[k[2:0]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      scnt_a <= '0; sinit_a <= 1'b1; ssh_a <= '0;
      scnt_b <= '0; sinit_b <= 1'b1; ssh_b <= '0;
    end else begin
      sinit_a <= 1'b0;
      sinit_b <= 1'b0;
      if (scnt_a == 4'd0) begin
        if (start_a) begin scnt_a <= 4'd1; ssh_a <= udata_a; end
      end else scnt_a <= (scnt_a == 4'd9) ? 4'd0 : scnt_a + 4'd1;
      if (scnt_b == 4'd0) begin
        if (start_b) begin scnt_b <= 4'd1; ssh_b <= udata_b; end
      end else scnt_b <= (scnt_b == 4'd9) ? 4'd0 : scnt_b + 4'd1;
    end
  end

  assign ir_a = (scnt_a == 4'd0) && !sinit_a;
  assign ir_b = (scnt_b == 4'd0) && !sinit_b;
  assign tx_a = tx_of(scnt_a, ssh_a);
  assign tx_b = tx_of(scnt_b, ssh_b);

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic prev_start_a = 1'b0, prev_start_b = 1'b0;
  int rem_a[4];
  int rem_b[4];
  int ga_idx[$];
  int ga_cyc[$];
  int gb_cyc[$];
  logic [7:0] ga_dat[$];
  logic tx_log_a[256];
  logic tx_log_b[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line pattern: start bit then data LSB first, bit i = cycle base+i
  function automatic logic [8:0] frame_bits(input logic [7:0] b);
    return {b, 1'b0};
  endfunction

  function automatic logic [8:0] tx_window(input bit sel_b, input int base);
    logic [8:0] v;
    for (int i = 0; i < 9; i++) v[i] = sel_b ? tx_log_b[base+i] : tx_log_a[base+i];
    return v;
  endfunction

  // One cycle: sample at negedge, check invariants, run the requester model
  task automatic step();
    @(negedge clk);
    cyc++;
    if (cyc >= 0 && cyc < 256) begin
      tx_log_a[cyc] = tx_a;
      tx_log_b[cyc] = tx_b;
    end
    chk("start_two_cycles", 32'((start_a && prev_start_a) || (start_b && prev_start_b)), 32'd0);
    chk("gnt_outside_issue", 32'((gnt_a != 0 && !start_a) || (gnt_b != 0 && !start_b)), 32'd0);
    prev_start_a = start_a;
    prev_start_b = start_b;
    for (int i = 0; i < 4; i++) begin
      if (gnt_a[i]) begin
        ga_idx.push_back(i);
        ga_cyc.push_back(cyc);
        ga_dat.push_back(udata_a);
        rem_a[i]--;
        if (rem_a[i] <= 0) req_a[i] = 1'b0;
        else data_a[8*i +: 8] = data_a[8*i +: 8] + 8'd1;
      end
      if (gnt_b[i]) begin
        gb_cyc.push_back(cyc);
        rem_b[i]--;
        if (rem_b[i] <= 0) req_b[i] = 1'b0;
        else data_b[8*i +: 8] = data_b[8*i +: 8] + 8'd1;
      end
    end
  endtask

  task automatic clear_logs();
    ga_idx.delete(); ga_cyc.delete(); ga_dat.delete(); gb_cyc.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_start", 32'(start_a), 32'd0);
    chk("rst_data", 32'(udata_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd1);
    chk("rst_cur_src", 32'(cur_a), 32'd3);
    chk("rst_frame_count", 32'(fc_a), 32'd0);
    chk("rst_b_cur_src", 32'(cur_b), 32'd3);
    rst = 1'b0;
    chk("init_busy", 32'(busy_a), 32'd1);
    step();
    chk("idle_busy", 32'(busy_a), 32'd0);
  endtask

  task automatic wait_grants(input bit sel_b, input int n, input int budget);
    int k = 0;
    while (((sel_b ? gb_cyc.size() : ga_idx.size()) < n) && k < budget) begin
      step();
      k++;
    end
    chk("grant_budget", 32'(sel_b ? gb_cyc.size() : ga_idx.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy_a !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    chk("idle_timeout", 32'(busy_a), 32'd0);
  endtask

  initial begin
    int exp_seq[11];
    logic [7:0] nxt1, nxt3;
    int run;

    // Reset and single request, STOP_CYCLES=2
    reset_dut();
    clear_logs();
    data_a[23:16] = 8'hA5; rem_a[2] = 1; req_a = 4'b0100; cyc = 0;
    step();
    chk("t1_gnt", 32'(gnt_a), 32'h4);
    chk("t1_start", 32'(start_a), 32'd1);
    chk("t1_data", 32'(udata_a), 32'hA5);
    chk("t1_cur_src", 32'(cur_a), 32'd2);
    chk("t1_busy_issue", 32'(busy_a), 32'd1);
    step();
    chk("t1_start_low", 32'(start_a), 32'd0);
    chk("t1_gnt_low", 32'(gnt_a), 32'd0);
    chk("t1_frame_count", 32'(fc_a), 32'd1);
    while (cyc < 13) step();
    chk("t1_busy_gap", 32'(busy_a), 32'd1);
    step();
    chk("t1_busy_idle", 32'(busy_a), 32'd0);
    chk("t1_tx_frame", 32'(tx_window(1'b0, 2)), 32'(frame_bits(8'hA5)));
    chk("t1_grants", 32'(ga_idx.size()), 32'd1);

    // All four requesters at once after reset
    reset_dut();
    clear_logs();
    data_a = 32'h44332211;
    for (int i = 0; i < 4; i++) rem_a[i] = 1;
    req_a = 4'hF; cyc = 0;
    wait_grants(1'b0, 4, 80);
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", 32'(ga_idx[k]), 32'(k));
      chk("t2_issue_cycle", 32'(ga_cyc[k]), 32'(1 + 14*k));
      chk("t2_byte", 32'(ga_dat[k]), 32'(8'h11 * (k + 1)));
    end
    step();
    chk("t2_frame_count", 32'(fc_a), 32'd4);
    wait_idle(40);

    // Fairness: req[1] streams 8 bytes, req[3] joins after the first grant
    clear_logs();
    data_a[15:8] = 8'h50; rem_a[1] = 8; req_a[1] = 1'b1; cyc = 0;
    step();
    chk("t3_first_gnt", 32'(gnt_a), 32'h2);
    data_a[31:24] = 8'h70; rem_a[3] = 3; req_a[3] = 1'b1;
    wait_grants(1'b0, 11, 250);
    exp_seq = '{1, 3, 1, 3, 1, 3, 1, 1, 1, 1, 1};
    nxt1 = 8'h50;
    nxt3 = 8'h70;
    for (int k = 0; k < 11; k++) begin
      chk("t3_order", 32'(ga_idx[k]), 32'(exp_seq[k]));
      chk("t3_issue_cycle", 32'(ga_cyc[k]), 32'(1 + 14*k));
      if (exp_seq[k] == 1) begin
        chk("t3_byte_src1", 32'(ga_dat[k]), 32'(nxt1));
        nxt1 = nxt1 + 8'd1;
      end else begin
        chk("t3_byte_src3", 32'(ga_dat[k]), 32'(nxt3));
        nxt3 = nxt3 + 8'd1;
      end
    end
    wait_idle(40);
    chk("t3_frame_count", 32'(fc_a), 32'd15);

    // STOP_CYCLES=0 instance: 12-cycle spacing, tx high 3 cycles between frames
    clear_logs();
    data_b[7:0] = 8'h0F; rem_b[0] = 3; req_b[0] = 1'b1; cyc = 0;
    wait_grants(1'b1, 3, 60);
    for (int k = 0; k < 3; k++) chk("t4_issue_cycle", 32'(gb_cyc[k]), 32'(1 + 12*k));
    chk("t4_tx_frame", 32'(tx_window(1'b1, 2)), 32'(frame_bits(8'h0F)));
    run = 0;
    for (int i = 11; i < 40; i++) begin
      if (tx_log_b[i] !== 1'b1) break;
      run++;
    end
    chk("t4_tx_high_run", 32'(run), 32'd3);
    chk("t4_next_start_bit", 32'(tx_log_b[14]), 32'd0);
    for (int i = 0; i < 40; i++) step();

    // Reset in the middle of a frame with another request pending
    clear_logs();
    data_a[7:0] = 8'h3C; rem_a[0] = 1; req_a[0] = 1'b1; cyc = 0;
    step();
    chk("t5_first_gnt", 32'(gnt_a), 32'h1);
    while (cyc < 3) step();
    data_a[23:16] = 8'h96; rem_a[2] = 1; req_a[2] = 1'b1;
    while (cyc < 6) step();
    rst = 1'b1;
    step();
    chk("t5_rst_gnt", 32'(gnt_a), 32'd0);
    chk("t5_rst_start", 32'(start_a), 32'd0);
    chk("t5_rst_tx", 32'(tx_a), 32'd1);
    chk("t5_rst_busy", 32'(busy_a), 32'd1);
    chk("t5_rst_cur_src", 32'(cur_a), 32'd3);
    chk("t5_rst_frame_count", 32'(fc_a), 32'd0);
    rst = 1'b0;
    step();
    chk("t5_idle_busy", 32'(busy_a), 32'd0);
    step();
    chk("t5_reissue_gnt", 32'(gnt_a), 32'h4);
    chk("t5_reissue_start", 32'(start_a), 32'd1);
    chk("t5_reissue_data", 32'(udata_a), 32'h96);
    while (cyc < 19) step();
    chk("t5_tx_frame", 32'(tx_window(1'b0, 10)), 32'(frame_bits(8'h96)));
    wait_idle(40);

    // frame_count wrap: preload 0xFFFF, then arbitrate two requesters
    force dut_a.fcount_q = 16'hFFFF;
    step();
    release dut_a.fcount_q;
    step();
    chk("t6_preload", 32'(fc_a), 32'hFFFF);
    clear_logs();
    data_a[7:0] = 8'hC3; data_a[31:24] = 8'hE7;
    rem_a[0] = 1; rem_a[3] = 1; req_a = 4'b1001; cyc = 0;
    step();
    chk("t6_gnt", 32'(gnt_a), 32'h8);
    chk("t6_data", 32'(udata_a), 32'hE7);
    step();
    chk("t6_wrap", 32'(fc_a), 32'h0);
    wait_grants(1'b0, 2, 40);
    chk("t6_second_src", 32'(ga_idx[1]), 32'd0);
    chk("t6_second_cycle", 32'(ga_cyc[1]), 32'd15);
    chk("t6_second_byte", 32'(ga_dat[1]), 32'hC3);
    step();
    chk("t6_frame_count", 32'(fc_a), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
